// File: rtl/vai_pkg.sv
// Shared definitions for the VAI byte-stream register protocol: command codes,
// header field layout and the request-master state encoding.
package vai_pkg;

  localparam logic [3:0] CMD_READ  = 4'h0;
  localparam logic [3:0] CMD_WRITE = 4'h1;

  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 4;
  localparam int HDR_CMD_MSB  = 3;
  localparam int HDR_CMD_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_HDR  = 3'd1,
    ST_TX_DATA = 3'd2,
    ST_RX_HDR  = 3'd3,
    ST_RX_DATA = 3'd4,
    ST_RX_STOP = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  function automatic logic [7:0] make_hdr(input logic [3:0] addr, input logic [3:0] cmd);
    logic [7:0] h;
    h = '0;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    h[HDR_CMD_MSB:HDR_CMD_LSB]   = cmd;
    return h;
  endfunction

endpackage

// File: rtl/vai_master.sv
// VAI request master: turns one register read/write into a request frame and
// folds the response frame into one result. Optional watchdog: VAI_MASTER_TIMEOUT_EN.
module vai_master
  import vai_pkg::*;
#(
  parameter int TimeoutCycles = 64
) (
  input  logic       Clk_i,
  input  logic       Reset_n_i,
  input  logic       ReqValid_i,
  output logic       ReqAccept_o,
  input  logic       ReqWrite_i,
  input  logic [3:0] ReqAddr_i,
  input  logic [7:0] ReqData_i,
  output logic       RspValid_o,
  input  logic       RspAccept_i,
  output logic [7:0] RspData_o,
  output logic       RspError_o,
  output logic       RspProtoErr_o,
  output logic [7:0] Dout_o,
  output logic       DoutValid_o,
  output logic       DoutStart_o,
  output logic       DoutStop_o,
  input  logic       DoutAccept_i,
  input  logic [7:0] Din_i,
  input  logic       DinValid_i,
  input  logic       DinStart_i,
  input  logic       DinStop_i,
  output logic       DinAccept_o
);

  state_t     state, state_nxt;
  logic       req_write;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] rx_data;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_proto;

  logic [7:0] hdr;
  logic       in_rx;
  logic       hdr_bad, data_bad, stop_bad;
  logic       rx_fail, stop_ok, req_take;
  logic       timeout;

  assign hdr      = make_hdr(req_addr, req_write ? CMD_WRITE : CMD_READ);
  assign in_rx    = (state == ST_RX_HDR) || (state == ST_RX_DATA) || (state == ST_RX_STOP);
  assign hdr_bad  = !DinStart_i || (Din_i != hdr);
  assign data_bad = DinStart_i || DinStop_i;
  assign stop_bad = !DinStop_i || (Din_i[7:1] != 7'd0);
  assign req_take = (state == ST_IDLE) && ReqValid_i;
  assign stop_ok  = (state == ST_RX_STOP) && DinValid_i && !stop_bad;

  assign rx_fail = ((state == ST_RX_HDR)  && DinValid_i && hdr_bad)
                || ((state == ST_RX_DATA) && DinValid_i && data_bad)
                || ((state == ST_RX_STOP) && DinValid_i && stop_bad)
                || (in_rx && !DinValid_i && timeout);

`ifdef VAI_MASTER_TIMEOUT_EN
  localparam int Limit = (TimeoutCycles < 1) ? 1 : TimeoutCycles;
  localparam int CntW  = $clog2(Limit + 1);

  logic [CntW-1:0] to_cnt;

  // Counts idle response cycles; any consumed beat restarts the window.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      to_cnt <= '0;
    end else if (!in_rx || DinValid_i) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = in_rx && (to_cnt == CntW'(Limit - 1));
`else
  // Watchdog compiled out: the master waits for the response indefinitely.
  assign timeout = 1'b0 & (TimeoutCycles != 0);
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (ReqValid_i) state_nxt = ST_TX_HDR;
      ST_TX_HDR:  if (DoutAccept_i) state_nxt = req_write ? ST_TX_DATA : ST_RX_HDR;
      ST_TX_DATA: if (DoutAccept_i) state_nxt = ST_RX_HDR;
      ST_RX_HDR: begin
        if (rx_fail)         state_nxt = ST_RESP;
        else if (DinValid_i) state_nxt = req_write ? ST_RX_STOP : ST_RX_DATA;
      end
      ST_RX_DATA: begin
        if (rx_fail)         state_nxt = ST_RESP;
        else if (DinValid_i) state_nxt = ST_RX_STOP;
      end
      ST_RX_STOP: if (rx_fail || DinValid_i) state_nxt = ST_RESP;
      ST_RESP:    if (RspAccept_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Request fields only matter outside IDLE, so they are captured without reset.
  always_ff @(posedge Clk_i) begin
    if (req_take) begin
      req_write <= ReqWrite_i;
      req_addr  <= ReqAddr_i;
      req_data  <= ReqData_i;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (req_take) begin
      rx_data <= 8'h00;
    end else if ((state == ST_RX_DATA) && DinValid_i && !data_bad) begin
      rx_data <= Din_i;
    end
  end

  // Result is cleared at request time so writes and failed frames report 0x00.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      rsp_proto <= 1'b0;
    end else if (req_take) begin
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      rsp_proto <= 1'b0;
    end else if (rx_fail) begin
      rsp_proto <= 1'b1;
    end else if (stop_ok) begin
      rsp_data <= rx_data;
      rsp_err  <= Din_i[0];
    end
  end

  always_comb begin
    ReqAccept_o = 1'b0;
    DoutValid_o = 1'b0;
    DoutStart_o = 1'b0;
    DoutStop_o  = 1'b0;
    Dout_o      = 8'h00;
    DinAccept_o = 1'b0;
    RspValid_o  = 1'b0;
    unique case (state)
      ST_IDLE: ReqAccept_o = 1'b1;
      ST_TX_HDR: begin
        DoutValid_o = 1'b1;
        DoutStart_o = 1'b1;
        DoutStop_o  = !req_write;
        Dout_o      = hdr;
      end
      ST_TX_DATA: begin
        DoutValid_o = 1'b1;
        DoutStop_o  = 1'b1;
        Dout_o      = req_data;
      end
      ST_RX_HDR, ST_RX_DATA, ST_RX_STOP: DinAccept_o = 1'b1;
      ST_RESP: RspValid_o = 1'b1;
      default: ;
    endcase
  end

  assign RspData_o     = rsp_data;
  assign RspError_o    = rsp_err;
  assign RspProtoErr_o = rsp_proto;

endmodule

// File: tb/tb_vai_master.sv
// Directed bench for vai_master: table of register transactions against a small
// behavioural slave, plus reset, stall and watchdog sequences.
module tb_vai_master;

  logic       clk = 1'b0;
  logic       Reset_n_i;
  logic       ReqValid_i, ReqWrite_i;
  logic [3:0] ReqAddr_i;
  logic [7:0] ReqData_i;
  logic       ReqAccept_o;
  logic       RspValid_o, RspAccept_i;
  logic [7:0] RspData_o;
  logic       RspError_o, RspProtoErr_o;
  logic [7:0] Dout_o;
  logic       DoutValid_o, DoutStart_o, DoutStop_o, DoutAccept_i;
  logic [7:0] Din_i;
  logic       DinValid_i, DinStart_i, DinStop_i, DinAccept_o;

  always #5 clk = ~clk;

  vai_master #(.TimeoutCycles(16)) dut (
    .Clk_i(clk), .Reset_n_i(Reset_n_i),
    .ReqValid_i(ReqValid_i), .ReqAccept_o(ReqAccept_o), .ReqWrite_i(ReqWrite_i),
    .ReqAddr_i(ReqAddr_i), .ReqData_i(ReqData_i),
    .RspValid_o(RspValid_o), .RspAccept_i(RspAccept_i), .RspData_o(RspData_o),
    .RspError_o(RspError_o), .RspProtoErr_o(RspProtoErr_o),
    .Dout_o(Dout_o), .DoutValid_o(DoutValid_o), .DoutStart_o(DoutStart_o),
    .DoutStop_o(DoutStop_o), .DoutAccept_i(DoutAccept_i),
    .Din_i(Din_i), .DinValid_i(DinValid_i), .DinStart_i(DinStart_i),
    .DinStop_i(DinStop_i), .DinAccept_o(DinAccept_o)
  );

  // mode: 0 normal, 1 corrupt header (^0x10), 2 stop byte 0x02,
  //       3 Stop set on read data beat, 4 Stop missing on stop beat
  typedef struct {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         mode;
    int         stall;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] rd;
    logic       err;
    logic       proto;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] regs[8];
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] b, input logic s, input logic p);
    Din_i = b; DinStart_i = s; DinStop_i = p; DinValid_i = 1'b1;
    @(negedge clk);
    DinValid_i = 1'b0; Din_i = 8'h00; DinStart_i = 1'b0; DinStop_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] rd;
    logic       eb;
    check("req_accept_idle", ReqAccept_o, 1);
    ReqValid_i = 1'b1; ReqWrite_i = v.write; ReqAddr_i = v.addr; ReqData_i = v.wdata;
    @(negedge clk);
    ReqValid_i = 1'b0;
    check("req_accept_busy", ReqAccept_o, 0);
    for (int s = 0; s <= v.stall; s++) begin
      check("hdr_valid", DoutValid_o, 1);
      check("hdr_byte", Dout_o, v.b0);
      check("hdr_start", DoutStart_o, 1);
      check("hdr_stop", DoutStop_o, !v.write);
      if (s < v.stall) @(negedge clk);
    end
    DoutAccept_i = 1'b1;
    @(negedge clk);
    if (v.write) begin
      check("data_valid", DoutValid_o, 1);
      check("data_byte", Dout_o, v.b1);
      check("data_start", DoutStart_o, 0);
      check("data_stop", DoutStop_o, 1);
      @(negedge clk);
    end
    DoutAccept_i = 1'b0;
    check("tx_done_valid", DoutValid_o, 0);
    check("din_accept", DinAccept_o, 1);
    if (v.write && v.addr < 8) regs[v.addr[2:0]] = v.wdata;
    rd = (v.addr < 8) ? regs[v.addr[2:0]] : 8'h00;
    eb = (v.addr >= 8);
    send_beat((v.mode == 1) ? (v.b0 ^ 8'h10) : v.b0, 1'b1, 1'b0);
    if (v.mode != 1) begin
      if (!v.write) begin
        @(negedge clk);
        check("gap_din_accept", DinAccept_o, 1);
        send_beat(rd, 1'b0, v.mode == 3);
      end
      if (v.mode != 3) begin
        send_beat((v.mode == 2) ? 8'h02 : {7'd0, eb}, 1'b0, v.mode != 4);
      end
    end
    check("rsp_valid", RspValid_o, 1);
    check("rsp_data", RspData_o, v.rd);
    check("rsp_err", RspError_o, v.err);
    check("rsp_proto", RspProtoErr_o, v.proto);
    repeat (2) @(negedge clk);
    check("rsp_hold_valid", RspValid_o, 1);
    check("rsp_hold_data", RspData_o, v.rd);
    check("rsp_hold_proto", RspProtoErr_o, v.proto);
    RspAccept_i = 1'b1;
    @(negedge clk);
    RspAccept_i = 1'b0;
    check("rsp_released", RspValid_o, 0);
    check("back_to_idle", ReqAccept_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n_i = 1'b0; ReqValid_i = 1'b0; ReqWrite_i = 1'b0; ReqAddr_i = 4'h0;
    ReqData_i = 8'h00; RspAccept_i = 1'b0; DoutAccept_i = 1'b0; Din_i = 8'h00;
    DinValid_i = 1'b0; DinStart_i = 1'b0; DinStop_i = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;

    //          wr    addr  wdata  mode stall b0     b1     rd     err   proto
    vecs[0]  = '{1'b1, 4'h3, 8'hA5, 0, 0, 8'h31, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h3, 8'h00, 0, 0, 8'h30, 8'h00, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h9, 8'h00, 0, 0, 8'h90, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'h5, 8'h3C, 0, 3, 8'h51, 8'h3C, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'h5, 8'h00, 0, 2, 8'h50, 8'h00, 8'h3C, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'h3, 8'h5A, 1, 0, 8'h31, 8'h5A, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 4'hC, 8'h77, 0, 0, 8'hC1, 8'h77, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'h5, 8'h00, 2, 0, 8'h50, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'h5, 8'h00, 3, 0, 8'h50, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'h1, 8'h11, 4, 0, 8'h11, 8'h11, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'h5, 8'h00, 0, 1, 8'h50, 8'h00, 8'h3C, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_req_accept", ReqAccept_o, 1);
    check("rst_dout_valid", DoutValid_o, 0);
    check("rst_dout_start", DoutStart_o, 0);
    check("rst_dout_stop", DoutStop_o, 0);
    check("rst_din_accept", DinAccept_o, 0);
    check("rst_rsp_valid", RspValid_o, 0);
    check("rst_rsp_data", RspData_o, 0);
    Reset_n_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset in the middle of a request frame
    ReqValid_i = 1'b1; ReqWrite_i = 1'b1; ReqAddr_i = 4'h2; ReqData_i = 8'h99;
    @(negedge clk);
    ReqValid_i = 1'b0;
    check("mid_hdr_valid", DoutValid_o, 1);
    #2 Reset_n_i = 1'b0;
    #1;
    check("mid_rst_req_accept", ReqAccept_o, 1);
    check("mid_rst_dout_valid", DoutValid_o, 0);
    check("mid_rst_dout_start", DoutStart_o, 0);
    @(negedge clk);
    Reset_n_i = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    @(negedge clk);
    run_vec('{1'b1, 4'h2, 8'h66, 0, 0, 8'h21, 8'h66, 8'h00, 1'b0, 1'b0});
    run_vec('{1'b0, 4'h2, 8'h00, 0, 0, 8'h20, 8'h00, 8'h66, 1'b0, 1'b0});

`ifdef VAI_MASTER_TIMEOUT_EN
    // No response at all: watchdog fires 16 cycles after entering RX_HDR
    ReqValid_i = 1'b1; ReqWrite_i = 1'b0; ReqAddr_i = 4'h2;
    @(negedge clk);
    ReqValid_i = 1'b0;
    DoutAccept_i = 1'b1;
    @(negedge clk);
    DoutAccept_i = 1'b0;
    check("to_in_rx", DinAccept_o, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("to_not_yet", RspValid_o, 0);
      if (k == 16) begin
        check("to_rsp_valid", RspValid_o, 1);
        check("to_proto", RspProtoErr_o, 1);
        check("to_data", RspData_o, 0);
      end
    end
    RspAccept_i = 1'b1;
    @(negedge clk);
    RspAccept_i = 1'b0;
    check("to_back_idle", ReqAccept_o, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vai_master.md
# vai_master

Request-side master for the VAI byte-stream register protocol. It converts single register read/write requests into VAI request frames and parses the returning VAI response frame into a single result word. It sits directly upstream of the VAI register slave: its `Dout*` port drives the slave's `Din*` port, and its `Din*` port consumes the slave's `Dout*` response stream.

## Interface
- `TimeoutCycles`, default 64: response watchdog limit in cycles; used only with `VAI_MASTER_TIMEOUT_EN`.
- `Clk_i` in 1: clock. Single clock domain.
- `Reset_n_i` in 1: reset, asynchronous, active-low.
- `ReqValid_i` in 1: request valid.
- `ReqAccept_o` out 1: request accepted.
- `ReqWrite_i` in 1: 1 = write, 0 = read.
- `ReqAddr_i` in 4: register address, placed in header[7:4].
- `ReqData_i` in 8: write data.
- `RspValid_o` out 1: result valid.
- `RspAccept_i` in 1: result consumed.
- `RspData_o` out 8: read data; 0x00 for writes.
- `RspError_o` out 1: error byte reported by the slave in the stop beat (bit 0).
- `RspProtoErr_o` out 1: malformed response, or timeout.
- `Dout_o` out 8: request byte to the slave.
- `DoutValid_o` out 1: request beat valid.
- `DoutStart_o` out 1: first beat of the request frame.
- `DoutStop_o` out 1: last beat of the request frame.
- `DoutAccept_i` in 1: slave accepted the beat.
- `Din_i` in 8: response byte from the slave.
- `DinValid_i` in 1: response beat valid.
- `DinStart_i` in 1: first beat of the response frame.
- `DinStop_i` in 1: last beat of the response frame.
- `DinAccept_o` out 1: master accepts the response beat.

## Operation
- Header byte = {addr[3:0], cmd[3:0]}, with cmd READ=0x0 and WRITE=0x1.
- Read request: one beat carrying the header, with Start=1 and Stop=1.
- Write request: a header beat (Start=1, Stop=0), then a data beat (Start=0, Stop=1, byte = write data).
- Expected response:
  - first a header beat with Start=1 whose byte equals the sent header;
  - for reads only, one data beat with Start=0 and Stop=0;
  - finally a stop beat with Stop=1 carrying the error byte (0x00 or 0x01).
- FSM states: IDLE, TX_HDR, TX_DATA, RX_HDR, RX_DATA, RX_STOP, RESP.
- IDLE:
  - `ReqAccept_o`=1.
  - On `ReqValid_i` it captures write/addr/data and goes to TX_HDR.
- TX_HDR:
  - Drives the header beat.
  - On `DoutAccept_i` it goes to TX_DATA (write) or RX_HDR (read).
- TX_DATA:
  - Drives the data beat.
  - On `DoutAccept_i` it goes to RX_HDR.
- RX_HDR, RX_DATA, RX_STOP:
  - `DinAccept_o`=1; each beat is consumed when `DinValid_i` is high.
  - Beats with `DinValid_i`=0 (gaps) are ignored.
- Response checks: any mismatch sets `RspProtoErr_o`=1 and moves the FSM to RESP immediately. A mismatch is any of:
  - Start missing on the header beat, or a header byte mismatch;
  - Start or Stop set on the read data beat;
  - Stop missing on the stop beat;
  - a stop byte other than 0x00 or 0x01.
- On a valid stop beat:
  - `RspError_o` = Din_i[0];
  - `RspData_o` = the captured data byte;
  - the FSM goes to RESP.
- RESP: `RspValid_o`=1, held with stable outputs until `RspAccept_i`, then IDLE.
- Address values 8..15 are sent unchanged. The slave reports them with error=1 and read data 0x00; the master passes this through.

## Timing
- Reset values: all outputs 0, except `ReqAccept_o`=1, since the FSM enters IDLE asynchronously.
- Request handshake in cycle N gives `DoutValid_o`=1 with the header in cycle N+1. Outputs are registered.
- While `DoutValid_o` && !`DoutAccept_i`, the signals `Dout_o`, `DoutStart_o` and `DoutStop_o` hold stable.
- `DoutStart_o` and `DoutStop_o` are only high together with `DoutValid_o`.
- Header accepted in cycle M gives the data beat in cycle M+1. There is no idle gap between request beats.
- `DinAccept_o` is combinational from state, with no dependency on `DinValid_i`. The master never stalls the slave.
- The stop beat consumed in cycle K gives `RspValid_o`=1 in cycle K+1.
- `RspAccept_i` in RESP gives `ReqAccept_o`=1 in the next cycle. Back-to-back requests have a minimum 1-cycle IDLE gap.
- Reset asserted mid-frame: immediate return to IDLE, and the partial frame is abandoned. The slave is reset by the same reset.
- `ReqValid_i` while not in IDLE is ignored. `ReqAccept_o`=0.

## Configuration
- `VAI_MASTER_TIMEOUT_EN` defined:
  - A counter runs in the RX_* states and is cleared on each consumed beat.
  - When it reaches `TimeoutCycles`, the FSM goes to RESP with `RspProtoErr_o`=1 and `RspData_o`=0x00.
- `VAI_MASTER_TIMEOUT_EN` undefined: no counter; the master waits indefinitely for the response.

## Structure
- Shared package `vai_pkg` holds:
  - cmd constants READ/WRITE;
  - the header field slices (addr [7:4], cmd [3:0]);
  - the FSM state enum typedef.
- Single module with no sub-module. The timeout counter lives inside the conditional compile region.

## Test plan
- Write addr 3, data 0xA5 with the slave connected:
  - request beats: 0x31 (Start), then 0xA5 (Stop);
  - result: RspError_o=0, RspData_o=0x00, RspProtoErr_o=0.
- Read addr 3 after that write:
  - request beat 0x30 with Start and Stop;
  - result: RspData_o=0xA5, RspError_o=0.
- Read addr 9: the request frame is sent; result RspError_o=1, RspData_o=0x00, RspProtoErr_o=0.
- Hold `DoutAccept_i`=0 for 3 cycles on the header beat: Dout_o, DoutStart_o and DoutStop_o stay stable; the frame completes normally afterwards.
- Modelled slave returns header 0x21 for sent 0x31: RspProtoErr_o=1 one cycle after the bad beat; RESP holds until RspAccept_i.
- With `VAI_MASTER_TIMEOUT_EN` and `TimeoutCycles`=16, no response: `RspValid_o` and `RspProtoErr_o` rise 16 cycles after entering RX_HDR.
